// File: rtl/vector_fetch_unit.sv
// vector_fetch_unit: walks a vector list in the 4 KB vector RAM, handles the JMPL, JSRL, RTSL
// and HALT flow-control words itself, and streams the drawing words (VCTR, SVEC, STAT, CNTR)
// to the vector decoder over a valid/ready handshake.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   go         one-cycle start pulse; ignored unless idle
//   vgrst      one-cycle abort pulse; returns to idle and keeps the error flag
//   bram_addr  byte address into the vector RAM
//   bram_rd_en read strobe; data returns one cycle later on bram_data
//   bram_data  read data
//   out_word   {hi byte, lo byte} of the current word
//   out_second out_word is the operand word of a VCTR
//   out_valid  out_word is valid
//   out_ready  decoder accepts the word
//   halted     1 while idle
//   error      sticky return-stack overflow/underflow flag
module vector_fetch_unit #(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        vgrst,
  output logic [11:0] bram_addr,
  output logic        bram_rd_en,
  input  logic [7:0]  bram_data,
  output logic [15:0] out_word,
  output logic        out_second,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        halted,
  output logic        error
);

  localparam int unsigned AW  = $clog2(STACK_DEPTH);
  localparam int unsigned SpW = AW + 1;
  localparam logic [SpW-1:0] SpFull = SpW'(STACK_DEPTH);

  localparam logic [2:0] OpVctr = 3'b000;
  localparam logic [2:0] OpHalt = 3'b001;
  localparam logic [2:0] OpSvec = 3'b010;
  localparam logic [2:0] OpStat = 3'b011;
  localparam logic [2:0] OpCntr = 3'b100;
  localparam logic [2:0] OpJsrl = 3'b101;
  localparam logic [2:0] OpRtsl = 3'b110;
  localparam logic [2:0] OpJmpl = 3'b111;

  typedef enum logic [2:0] {StIdle, StFetchLo, StFetchHi, StCapture, StExec} state_e;

  state_e          state_q, state_d;
  logic [10:0]     pc_q, pc_d;
  logic [SpW-1:0]  sp_q, sp_d;
  logic [7:0]      lo_q, lo_d, hi_q, hi_d;
  logic            flag_q, flag_d;
  logic            error_q, error_d;
  logic            push;
  logic [10:0]     stack_q [STACK_DEPTH];

  logic [2:0]      opcode;
  logic [10:0]     target;
  logic [SpW-1:0]  sp_m1;
  logic            emit;

  assign opcode = hi_q[7:5];
  assign target = {hi_q[2:0], lo_q};
  assign sp_m1  = sp_q - SpW'(1);
  // The operand word of a VCTR is emitted without being decoded.
  assign emit   = flag_q || (opcode inside {OpVctr, OpSvec, OpStat, OpCntr});

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      sp_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      flag_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      flag_q  <= flag_d;
      error_q <= error_d;
    end
  end

  // Return stack needs no reset: entries are only read below sp.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[sp_q[AW-1:0]] <= pc_q + 11'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    flag_d  = flag_q;
    error_d = error_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          pc_d    = '0;
          sp_d    = '0;
          error_d = 1'b0;
          flag_d  = 1'b0;
          state_d = StFetchLo;
        end
      end
      StFetchLo: state_d = StFetchHi;
      StFetchHi: begin
        lo_d    = bram_data;
        state_d = StCapture;
      end
      StCapture: begin
        hi_d    = bram_data;
        state_d = StExec;
      end
      StExec: begin
        if (emit) begin
          if (out_ready) begin
            pc_d    = pc_q + 11'd1;
            flag_d  = !flag_q && (opcode == OpVctr);
            state_d = StFetchLo;
          end
        end else begin
          unique case (opcode)
            OpJmpl: begin
              pc_d    = target;
              state_d = StFetchLo;
            end
            OpJsrl: begin
              if (sp_q == SpFull) begin
                error_d = 1'b1;
                state_d = StIdle;
              end else begin
                push    = 1'b1;
                sp_d    = sp_q + SpW'(1);
                pc_d    = target;
                state_d = StFetchLo;
              end
            end
            OpRtsl: begin
              if (sp_q == '0) begin
                error_d = 1'b1;
                state_d = StIdle;
              end else begin
                sp_d    = sp_m1;
                pc_d    = stack_q[sp_m1[AW-1:0]];
                state_d = StFetchLo;
              end
            end
            default: state_d = StIdle;  // HALT
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over everything, including a simultaneous go; error is kept.
    if (vgrst) begin
      state_d = StIdle;
      pc_d    = '0;
      sp_d    = '0;
      flag_d  = 1'b0;
      error_d = error_q;
      push    = 1'b0;
    end
  end

  // Outputs decoded from state and registers only; out_ready never reaches them.
  always_comb begin
    halted     = (state_q == StIdle);
    bram_rd_en = (state_q == StFetchLo) || (state_q == StFetchHi);
    bram_addr  = '0;
    if (state_q == StFetchLo) bram_addr = {pc_q, 1'b0};
    if (state_q == StFetchHi) bram_addr = {pc_q, 1'b1};
    out_valid  = (state_q == StExec) && emit;
    out_word   = {hi_q, lo_q};
    out_second = flag_q;
    error      = error_q;
  end

endmodule

// File: tb/tb_vector_fetch_unit.sv
module tb_vector_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, go, vgrst, out_ready;
  logic [11:0] bram_addr;
  logic        bram_rd_en;
  logic [7:0]  bram_data = 8'h00;
  logic [15:0] out_word;
  logic        out_second, out_valid, halted, error;

  int errors = 0;
  int checks = 0;
  int overlap = 0;
  logic [16:0] sb [$];
  logic [7:0]  mem [4096];

  vector_fetch_unit #(.STACK_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .vgrst      (vgrst),
    .bram_addr  (bram_addr),
    .bram_rd_en (bram_rd_en),
    .bram_data  (bram_data),
    .out_word   (out_word),
    .out_second (out_second),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .halted     (halted),
    .error      (error)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle read latency.
  always @(posedge clk) if (bram_rd_en) bram_data <= mem[bram_addr];

  // Scoreboard: every transfer pops one expected {second, word}.
  always @(negedge clk) begin
    if (rst && bram_rd_en && out_valid) overlap++;
    if (rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got %h/%0b, none expected", out_word, out_second);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        if ({out_second, out_word} !== e) begin
          errors++;
          $display("FAIL xfer: got %h/%0b, expected %h/%0b", out_word, out_second, e[15:0], e[16]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic pulse_vgrst();
    vgrst = 1'b1;
    tick();
    vgrst = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  endtask

  task automatic load(input int a, input logic [15:0] w);
    mem[2*a]   = w[7:0];
    mem[2*a+1] = w[15:8];
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (!halted && n < 400) begin
      tick();
      n++;
    end
    chk(name, 32'(halted), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk(name, 32'(out_valid), 32'd1);
  endtask

  typedef struct {
    string            name;
    logic [5:0][15:0] prog;
    int               nexp;
    logic [2:0][16:0] exp;
    logic             err;
  } vec_t;

  function automatic logic [5:0][15:0] p6(input logic [15:0] a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction

  function automatic logic [2:0][16:0] e3(input logic [16:0] a, b, c);
    return {c, b, a};
  endfunction

  vec_t vecs [6];

  initial begin
    rst = 1'b0; go = 1'b0; vgrst = 1'b0; out_ready = 1'b1;
    clear_mem();
    repeat (3) tick();
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_en", 32'(bram_rd_en), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);
    chk("rst_word", 32'(out_word), 32'd0);
    chk("rst_second", 32'(out_second), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst = 1'b1;
    tick();

    // Basic emit with exact cycle timing.
    load(0, 16'h4123); load(1, 16'h2000);
    sb.push_back({1'b0, 16'h4123});
    pulse_go();                                   // cycle k+1
    chk("t_fl_halted", 32'(halted), 32'd0);
    chk("t_fl_rd", 32'(bram_rd_en), 32'd1);
    chk("t_fl_addr", 32'(bram_addr), 32'h000);
    tick();                                       // k+2
    chk("t_fh_addr", 32'(bram_addr), 32'h001);
    chk("t_fh_valid", 32'(out_valid), 32'd0);
    tick();                                       // k+3
    chk("t_cap_rd", 32'(bram_rd_en), 32'd0);
    chk("t_cap_valid", 32'(out_valid), 32'd0);
    tick();                                       // k+4
    chk("t_ex_valid", 32'(out_valid), 32'd1);
    tick(); tick(); tick(); tick();               // k+8: EXEC of HALT
    chk("t_halt_exec", 32'(halted), 32'd0);
    tick();
    chk("t_halt_after", 32'(halted), 32'd1);
    chk("t_drain", 32'(sb.size()), 32'd0);

    // Back-pressure.
    out_ready = 1'b0;
    sb.push_back({1'b0, 16'h4123});
    pulse_go();
    wait_valid("bp_valid");
    for (int i = 0; i < 7; i++) begin
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_word_hold", 32'(out_word), 32'h4123);
      chk("bp_no_read", 32'(bram_rd_en), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_halted("bp_halt");
    chk("bp_drain", 32'(sb.size()), 32'd0);

    // Subroutine call and return.
    clear_mem();
    load(0, 16'hA010); load(1, 16'h2000); load(16, 16'h6001); load(17, 16'hC000);
    sb.push_back({1'b0, 16'h6001});
    pulse_go();
    wait_halted("sub_halt");
    chk("sub_drain", 32'(sb.size()), 32'd0);
    chk("sub_error", 32'(error), 32'd0);

    // Stack overflow: fifth JSRL faults, EXEC of it in cycle k+20.
    clear_mem();
    load(0, 16'hA000);
    pulse_go();
    repeat (19) tick();
    chk("ovf_busy", 32'(halted), 32'd0);
    chk("ovf_err_pre", 32'(error), 32'd0);
    tick();
    chk("ovf_halted", 32'(halted), 32'd1);
    chk("ovf_error", 32'(error), 32'd1);
    pulse_vgrst();
    chk("ovf_err_kept", 32'(error), 32'd1);

    // Abort during FETCH_HI.
    clear_mem();
    load(0, 16'h4123); load(1, 16'h2000);
    pulse_go();
    tick();
    chk("ab_in_fh", 32'(bram_addr), 32'h001);
    pulse_vgrst();
    chk("ab_idle", 32'(halted), 32'd1);
    repeat (6) tick();
    chk("ab_still_idle", 32'(halted), 32'd1);

    // vgrst with go.
    go = 1'b1; vgrst = 1'b1;
    tick();
    go = 1'b0; vgrst = 1'b0;
    chk("gv_idle", 32'(halted), 32'd1);
    repeat (4) tick();
    chk("gv_no_read", 32'(bram_rd_en), 32'd0);
    chk("gv_still_idle", 32'(halted), 32'd1);

    // JMPL to word 2047, then pc wraps to 0.
    clear_mem();
    load(0, 16'hE7FF); load(2047, 16'h4555);
    sb.push_back({1'b0, 16'h4555});
    pulse_go();
    wait_valid("wr_valid");
    tick();
    chk("wr_rd", 32'(bram_rd_en), 32'd1);
    chk("wr_addr", 32'(bram_addr), 32'h000);
    pulse_vgrst();
    chk("wr_drain", 32'(sb.size()), 32'd0);

    // Table-driven programs.
    vecs[0] = '{"basic", p6(16'h4123, 16'h2000, 0, 0, 0, 0), 1,
                e3({1'b0, 16'h4123}, 0, 0), 1'b0};
    vecs[1] = '{"vctr", p6(16'h0012, 16'h0034, 16'h2000, 0, 0, 0), 2,
                e3({1'b0, 16'h0012}, {1'b1, 16'h0034}, 0), 1'b0};
    vecs[2] = '{"stat_cntr", p6(16'h6001, 16'h8005, 16'h2000, 0, 0, 0), 2,
                e3({1'b0, 16'h6001}, {1'b0, 16'h8005}, 0), 1'b0};
    vecs[3] = '{"jmpl", p6(16'hF803, 16'h4111, 16'h2000, 16'h4222, 16'h2000, 0), 1,
                e3({1'b0, 16'h4222}, 0, 0), 1'b0};
    vecs[4] = '{"rtsl_uf", p6(16'hC000, 0, 0, 0, 0, 0), 0, e3(0, 0, 0), 1'b1};
    vecs[5] = '{"vctr_jmp_op", p6(16'h0000, 16'hE005, 16'h2000, 0, 0, 0), 2,
                e3({1'b0, 16'h0000}, {1'b1, 16'hE005}, 0), 1'b0};
    for (int v = 0; v < 6; v++) begin
      clear_mem();
      for (int w = 0; w < 6; w++) load(w, vecs[v].prog[w]);
      for (int x = 0; x < vecs[v].nexp; x++) sb.push_back(vecs[v].exp[x]);
      pulse_go();
      wait_halted({vecs[v].name, "_halt"});
      chk({vecs[v].name, "_drain"}, 32'(sb.size()), 32'd0);
      chk({vecs[v].name, "_error"}, 32'(error), 32'(vecs[v].err));
      sb.delete();
    end

    chk("no_rd_valid_overlap", 32'(overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
